// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box detector and the tracking stages after it.
package bbox_pkg;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_ACTIVE,
    ST_EMIT
  } bbox_state_e;

  localparam int COORD_W_DEF = 11;
  localparam int CNT_W       = 20;
  localparam int FG_BIT      = 7;

endpackage

// File: rtl/target_bbox_detect_if.sv
// Pixel-stream in / bounding-box out bundle for target_bbox_detect.
// fg_pix_cnt exists only when BBOX_MIN_PIX_EN is defined.
interface target_bbox_detect_if
  import bbox_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
);
  logic               per_frame_vsync;
  logic               per_frame_href;
  logic               per_frame_clken;
  logic [7:0]         per_img_bit;
  logic [COORD_W-1:0] box_x_min;
  logic [COORD_W-1:0] box_x_max;
  logic [COORD_W-1:0] box_y_min;
  logic [COORD_W-1:0] box_y_max;
  logic               box_found;
  logic               box_valid;
`ifdef BBOX_MIN_PIX_EN
  logic [CNT_W-1:0]   fg_pix_cnt;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
    input  box_x_min, box_x_max, box_y_min, box_y_max, box_found, box_valid, fg_pix_cnt
  );
  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
    output box_x_min, box_x_max, box_y_min, box_y_max, box_found, box_valid, fg_pix_cnt
  );
`else
  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
    input  box_x_min, box_x_max, box_y_min, box_y_max, box_found, box_valid
  );
  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
    output box_x_min, box_x_max, box_y_min, box_y_max, box_found, box_valid
  );
`endif
endinterface

// File: rtl/frame_edge_det.sv
// Frame/line framing edge detector: registered copies of vsync/href and the derived edges.
module frame_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic href,
  output logic vs_rise,
  output logic vs_fall,
  output logic hs_fall
);
  logic vsync_r;
  logic href_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
    end else begin
      vsync_r <= vsync;
      href_r  <= href;
    end
  end

  assign vs_rise = vsync & ~vsync_r;
  assign vs_fall = ~vsync & vsync_r;
  assign hs_fall = ~href & href_r;
endmodule

// File: rtl/target_bbox_detect.sv
// Bounding box of foreground pixels per frame, published one clock after vsync falls.
// Optional BBOX_MIN_PIX_EN: require at least MIN_PIX foreground pixels and expose fg_pix_cnt.
module target_bbox_detect
  import bbox_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COORD_W    = COORD_W_DEF,
  parameter int MIN_PIX    = 16
) (
  input logic                 clk,
  input logic                 rst_n,
  target_bbox_detect_if.slave bus
);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_HEIGHT - 1);
  localparam logic [COORD_W-1:0] C_SAT  = '1;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    return (v == C_SAT) ? v : v + 1'b1;
  endfunction

  bbox_state_e        state;
  logic [COORD_W-1:0] x_cnt, y_cnt;
  logic [COORD_W-1:0] wx_min, wx_max, wy_min, wy_max;
  logic               hit;
  logic               vs_rise, vs_fall, hs_fall;
  logic               pix_qual, fg_upd, clr_ws, found_now;
  logic               unused_pix;

  frame_edge_det u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync   (bus.per_frame_vsync),
    .href    (bus.per_frame_href),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall),
    .hs_fall (hs_fall)
  );

  assign unused_pix = ^bus.per_img_bit;
  assign pix_qual   = (state == ST_ACTIVE) && bus.per_frame_vsync &&
                      bus.per_frame_href && bus.per_frame_clken;
  assign fg_upd     = pix_qual && bus.per_img_bit[FG_BIT] &&
                      (x_cnt <= X_LAST) && (y_cnt <= Y_LAST);
  // A rise seen in EMIT restarts accumulation without passing through IDLE.
  assign clr_ws     = vs_rise && ((state == ST_IDLE) || (state == ST_EMIT));

`ifdef BBOX_MIN_PIX_EN
  logic [CNT_W-1:0] fg_cnt;
  assign found_now = hit && (fg_cnt >= CNT_W'(MIN_PIX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fg_cnt         <= '0;
      bus.fg_pix_cnt <= '0;
    end else begin
      if (clr_ws)
        fg_cnt <= '0;
      else if (fg_upd && (fg_cnt != '1))
        fg_cnt <= fg_cnt + 1'b1;
      if ((state == ST_ACTIVE) && vs_fall)
        bus.fg_pix_cnt <= fg_cnt;
    end
  end
`else
  logic unused_min_pix;
  assign unused_min_pix = (MIN_PIX != 0);
  assign found_now      = hit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_SYNC;
      x_cnt         <= '0;
      y_cnt         <= '0;
      wx_min        <= '0;
      wx_max        <= '0;
      wy_min        <= '0;
      wy_max        <= '0;
      hit           <= 1'b0;
      bus.box_x_min <= '0;
      bus.box_x_max <= '0;
      bus.box_y_min <= '0;
      bus.box_y_max <= '0;
      bus.box_found <= 1'b0;
      bus.box_valid <= 1'b0;
    end else begin
      bus.box_valid <= 1'b0;

      if (hs_fall) begin
        x_cnt <= '0;
        if (state == ST_ACTIVE) y_cnt <= sat_inc(y_cnt);
      end else if (pix_qual) begin
        x_cnt <= sat_inc(x_cnt);
      end

      if (fg_upd) begin
        if (x_cnt < wx_min) wx_min <= x_cnt;
        if (x_cnt > wx_max) wx_max <= x_cnt;
        if (y_cnt < wy_min) wy_min <= y_cnt;
        if (y_cnt > wy_max) wy_max <= y_cnt;
        hit <= 1'b1;
      end

      if (clr_ws) begin
        wx_min <= X_LAST;
        wx_max <= '0;
        wy_min <= Y_LAST;
        wy_max <= '0;
        hit    <= 1'b0;
        x_cnt  <= '0;
        y_cnt  <= '0;
      end

      case (state)
        ST_SYNC:   if (!bus.per_frame_vsync) state <= ST_IDLE;
        ST_IDLE:   if (vs_rise) state <= ST_ACTIVE;
        ST_ACTIVE: begin
          if (vs_fall) begin
            state         <= ST_EMIT;
            bus.box_valid <= 1'b1;
            bus.box_found <= found_now;
            bus.box_x_min <= found_now ? wx_min : '0;
            bus.box_x_max <= found_now ? wx_max : '0;
            bus.box_y_min <= found_now ? wy_min : '0;
            bus.box_y_max <= found_now ? wy_max : '0;
          end
        end
        ST_EMIT:   state <= vs_rise ? ST_ACTIVE : ST_IDLE;
        default:   state <= ST_SYNC;
      endcase
    end
  end
endmodule

// File: doc/target_bbox_detect.md
Name: target_bbox_detect

Overview:
Consumes the binarised frame-difference stream (0/255 per pixel, with vsync/href/clken framing) from the diff stage. Tracks the min/max column and row of foreground pixels across one frame. At end of frame it publishes the bounding box of the moving object, held stable for the overlay/tracking stage until the next frame completes.

Parameters:
IMG_WIDTH, 640, active pixels per line; columns >= IMG_WIDTH are ignored
IMG_HEIGHT, 480, active lines per frame; rows >= IMG_HEIGHT are ignored
COORD_W, 11, width of x/y counters and box outputs (must hold IMG_WIDTH-1 and IMG_HEIGHT-1)
MIN_PIX, 16, minimum foreground pixel count for a valid box (used only with BBOX_MIN_PIX_EN)

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
per_frame_vsync  in  1  high while frame active; rise = frame start, fall = frame end
per_frame_href  in  1  high while line active
per_frame_clken  in  1  pixel qualifier
per_img_bit  in  8  binarised pixel; foreground when bit 7 = 1
box_x_min  out  COORD_W  leftmost foreground column of last completed frame
box_x_max  out  COORD_W  rightmost foreground column
box_y_min  out  COORD_W  top foreground row
box_y_max  out  COORD_W  bottom foreground row
box_found  out  1  level: last completed frame held a valid box
box_valid  out  1  one-cycle pulse: box outputs just updated
fg_pix_cnt  out  20  foreground pixel count of last frame (only with BBOX_MIN_PIX_EN)

Behaviour:
- Reset: all outputs 0. FSM = SYNC. vsync_r and href_r = 0. Counters = 0.
- Edges: vs_rise = vsync & ~vsync_r; vs_fall = ~vsync & vsync_r; hs_fall = ~href & href_r. Derived from inputs and 1-cycle registered copies.
- FSM states:
  - SYNC: discards any partial frame after reset. Goes to IDLE once vsync is sampled 0.
  - IDLE: on vs_rise, go to ACTIVE and clear the working set.
  - ACTIVE: accumulate. On vs_fall, go to EMIT.
  - EMIT: lasts one cycle, then IDLE. If vs_rise is seen in EMIT, go straight to ACTIVE with working set cleared.
- Working set cleared on entry to ACTIVE: wx_min = IMG_WIDTH-1, wx_max = 0, wy_min = IMG_HEIGHT-1, wy_max = 0, hit = 0, x_cnt = 0, y_cnt = 0.
- Pixel qualification: state ACTIVE & vsync & href & clken. A pixel sampled together with vsync low is not qualified.
- x_cnt increments per qualified pixel and saturates at 2^COORD_W-1. It is cleared on hs_fall.
- y_cnt increments on hs_fall in ACTIVE and saturates likewise.
- Foreground update: applies to a qualified pixel with per_img_bit[7] = 1, x_cnt < IMG_WIDTH and y_cnt < IMG_HEIGHT.
  - min/max updated using the current x_cnt/y_cnt (the pixel's own coordinates).
  - hit set to 1.
- Latching: at the clock edge that detects vs_fall, the outputs are registered.
  - If hit: box_* = working set, box_found = 1.
  - Else: box_* = 0, box_found = 0.
- box_valid is high for exactly the one cycle following that edge (the EMIT cycle). Latency from vsync fall to outputs valid = 1 clk.
- Box outputs and box_found hold until the next EMIT.
- Async reset mid-frame aborts accumulation. Outputs return to 0 and no box_valid is emitted for the interrupted frame.

Optional Feature:
BBOX_MIN_PIX_EN
- Defined:
  - A 20-bit saturating counter counts foreground updates; it is cleared on entry to ACTIVE.
  - At latch, box_found = hit & (count >= MIN_PIX). When not found, box_* = 0.
  - fg_pix_cnt is latched with the box and exists as a port.
- Undefined: no counter and no fg_pix_cnt port; box_found = hit; MIN_PIX unused.

Decomposition:
- Package bbox_pkg:
  - FSM state enum (SYNC, IDLE, ACTIVE, EMIT)
  - default COORD_W
  - CNT_W = 20
  - foreground bit index = 7
- Sub-module frame_edge_det: registers vsync/href and emits vs_rise, vs_fall, hs_fall. It is reused by later tracking stages.

Test Plan:
- Bench uses IMG_WIDTH=16, IMG_HEIGHT=8, 8 lines x 16 pixels. Stimulus: foreground only at (x=3,y=2) and (x=10,y=5) -> one cycle after vsync falls: box_valid=1 for 1 clk, box=(3,10,2,5), box_found=1.
- All-zero frame following the above -> box_found=0, box=0,0,0,0, box_valid pulses once.
- Foreground at (x=0,y=0) and (x=15,y=7), plus foreground driven at column 18 of an over-long line -> box=(0,15,0,7); the out-of-range pixel is ignored.
- Reset released while vsync=1 mid-frame with foreground present -> no box_valid for that frame; the next full frame with a pixel at (4,4) -> box=(4,4,4,4).
- vsync re-rises in the EMIT cycle; next frame has a pixel at (7,1) -> previous box is emitted correctly and the new frame yields box=(7,7,1,1), with no stale min/max carried over.
- With BBOX_MIN_PIX_EN, MIN_PIX=4: a 3-pixel frame gives box_found=0 and fg_pix_cnt=3; a 4-pixel frame gives box_found=1 and fg_pix_cnt=4.
